ev_id_arbiter: RTL and testbench
================================

Name: ev_id_arbiter

Overview:
- Shares one event_timestamper (ID_W/TS_W) among N_REQ requesters.
- Owns the ID namespace: allocates free IDs on start, arbitrates start and end events onto the timestamper's single start and end channels, and routes each result back to the requester that owns the ID.
- Frees an ID when its result is consumed.
- Sits between the requester-facing logic and the timestamper.

Parameters:
N_REQ, 2, number of requesters (2..8)
ID_W, 3, ID width; 2**ID_W IDs in the pool
TS_W, 8, timestamp/delta width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_start_valid  in  N_REQ  per-requester start request
req_start_ready  out  N_REQ  start accepted this cycle
req_start_id  out  N_REQ*ID_W  allocated ID, slice i valid when req_start_ready[i]
req_end_valid  in  N_REQ  per-requester end event
req_end_ready  out  N_REQ  end accepted
req_end_id  in  N_REQ*ID_W  ID being ended, slice i
ts_start_valid  out  1  to timestamper start channel
ts_start_ready  in  1
ts_start_id  out  ID_W
ts_end_valid  out  1  to timestamper end channel
ts_end_ready  in  1
ts_end_id  out  ID_W
ts_out_valid  in  1  timestamper result
ts_out_ready  out  1
ts_out_id  in  ID_W
ts_out_delta  in  TS_W
rsp_valid  out  N_REQ  result for requester i
rsp_ready  in  N_REQ
rsp_id  out  ID_W  broadcast, equals ts_out_id
rsp_delta  out  TS_W  broadcast, equals ts_out_delta
busy_cnt  out  ID_W+1  IDs currently allocated
err_end  out  1  one-cycle pulse on an illegal end

Behaviour:
- State per ID: busy, ended, owner[log2 N_REQ]. State also holds start_rr and end_rr pointers.
- Reset: busy=0, ended=0, owner=0, rr pointers=0, busy_cnt=0, err_end=0. All valid/ready outputs are 0 while rst=1.
- Start path (combinational from registered state):
  - Allocated ID = lowest-index ID with busy=0.
  - Grantee = first asserted req_start_valid at or after start_rr, wrapping.
  - ts_start_valid = any req_start_valid AND a free ID exists. ts_start_id = allocated ID.
  - req_start_ready[g] = ts_start_ready AND ts_start_valid, grantee only. Never depends on req_start_ready.
  - On handshake: busy[id]<=1, ended[id]<=0, owner[id]<=g, start_rr<=g+1 mod N_REQ.
- Pool full (busy_cnt = 2**ID_W): ts_start_valid=0 and all req_start_ready=0. Requests stall and are not dropped.
- End path:
  - Grantee = first asserted req_end_valid at or after end_rr, wrapping.
  - Legal end: busy[id]=1, owner[id]=g and ended[id]=0. It is forwarded: ts_end_valid=1, ts_end_id=id, req_end_ready[g]=ts_end_ready. On handshake: ended[id]<=1, end_rr<=g+1.
  - Illegal end: the end is consumed, not forwarded. req_end_ready[g]=1, ts_end_valid=0, err_end pulses the next cycle, end_rr<=g+1.
- Result path:
  - rsp_valid[owner[ts_out_id]] = ts_out_valid; all other rsp_valid bits are 0.
  - ts_out_ready = rsp_ready[owner[ts_out_id]].
  - Zero added latency; rsp_id and rsp_delta pass straight through.
  - On handshake: busy[id]<=0, ended[id]<=0.
- Simultaneous events:
  - An ID freed by a result this cycle is not reallocated until the next cycle, because allocation reads registered busy.
  - A start and a free in the same cycle leave busy_cnt unchanged. Otherwise busy_cnt is +1 on a start and -1 on a free.
  - The start and end channels are independent and may both fire in one cycle.
- A ts_out_id with busy=0 is protocol corruption. ts_out_ready=1, the result is dropped, err_end pulses.
- Reset mid-operation clears all state next edge. Outstanding timestamper results are the integrator's responsibility; the timestamper is reset on the same rst.

Test Plan:
- Both requesters assert start after reset, ts_start_ready=1 -> R0 gets ID 0 in cycle 1 and R1 gets ID 1 in cycle 2 (RR); busy_cnt=2.
- R0 starts 8 times with ts_start_ready=1 -> IDs 0..7 in order; 9th request stalls with req_start_ready=0 and busy_cnt=8. Result for ID 3 consumed -> 9th start gets ID 3 one cycle later, not the same cycle.
- R0 owns ID 2 and R1 owns ID 5; R1 ends ID 2 -> req_end_ready[1]=1, ts_end_valid=0, err_end=1 the next cycle; a second end of ID 5 by R1 also flags err_end.
- ts_out_valid with ts_out_id=5, delta=0x2A, rsp_ready[1]=0 for 3 cycles -> rsp_valid=2'b10 held and ts_out_ready=0; on rsp_ready[1]=1 the handshake frees ID 5 and busy_cnt decrements.
- Start grant, legal end and result handshake all in the same cycle -> all three complete; busy_cnt unchanged; the result's ID is not reissued that cycle.
- rst asserted with 4 IDs busy -> the next cycle has busy_cnt=0, all ready/valid outputs 0, and the first start after reset gets ID 0.

Source files
------------

// File: rtl/ev_id_arbiter_if.sv
// Requester, timestamper and response signals of the ID arbiter, grouped as one bundle.
// The slave modport is the arbiter's view. The master modport is the surrounding logic's view.
interface ev_id_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3,
  parameter int TS_W  = 8
);
  logic [N_REQ-1:0]      req_start_valid;
  logic [N_REQ-1:0]      req_start_ready;
  logic [N_REQ*ID_W-1:0] req_start_id;
  logic [N_REQ-1:0]      req_end_valid;
  logic [N_REQ-1:0]      req_end_ready;
  logic [N_REQ*ID_W-1:0] req_end_id;
  logic                  ts_start_valid;
  logic                  ts_start_ready;
  logic [ID_W-1:0]       ts_start_id;
  logic                  ts_end_valid;
  logic                  ts_end_ready;
  logic [ID_W-1:0]       ts_end_id;
  logic                  ts_out_valid;
  logic                  ts_out_ready;
  logic [ID_W-1:0]       ts_out_id;
  logic [TS_W-1:0]       ts_out_delta;
  logic [N_REQ-1:0]      rsp_valid;
  logic [N_REQ-1:0]      rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [TS_W-1:0]       rsp_delta;
  logic [ID_W:0]         busy_cnt;
  logic                  err_end;

  modport slave (
    input  req_start_valid, req_end_valid, req_end_id, ts_start_ready, ts_end_ready,
           ts_out_valid, ts_out_id, ts_out_delta, rsp_ready,
    output req_start_ready, req_start_id, req_end_ready, ts_start_valid, ts_start_id,
           ts_end_valid, ts_end_id, ts_out_ready, rsp_valid, rsp_id, rsp_delta,
           busy_cnt, err_end
  );

  modport master (
    output req_start_valid, req_end_valid, req_end_id, ts_start_ready, ts_end_ready,
           ts_out_valid, ts_out_id, ts_out_delta, rsp_ready,
    input  req_start_ready, req_start_id, req_end_ready, ts_start_valid, ts_start_id,
           ts_end_valid, ts_end_id, ts_out_ready, rsp_valid, rsp_id, rsp_delta,
           busy_cnt, err_end
  );
endinterface

// File: rtl/ev_id_arbiter.sv
// Shares one event timestamper among N_REQ requesters. Allocates IDs, round-robins the start and end channels,
// and routes each result back to the requester that owns its ID.
module ev_id_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3,
  parameter int TS_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  ev_id_arbiter_if.slave  bus
);
  localparam int N_ID = 1 << ID_W;
  localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [OW-1:0]   owner_t;
  typedef logic [ID_W-1:0] id_t;

  logic [N_ID-1:0] r_busy;
  logic [N_ID-1:0] r_ended;
  owner_t          r_owner [N_ID];
  owner_t          r_start_rr;
  owner_t          r_end_rr;
  logic [ID_W:0]   r_busy_cnt;
  logic            r_err_end;

  logic   w_free_found;
  id_t    w_alloc_id;
  owner_t w_start_g;
  owner_t w_end_g;
  owner_t w_out_owner;
  id_t    w_end_id;
  logic   w_start_valid;
  logic   w_start_fire;
  logic   w_any_end;
  logic   w_end_legal;
  logic   w_end_fire;
  logic   w_out_busy;
  logic   w_out_fire;
  logic   w_out_drop;

  function automatic owner_t f_rr_pick(input logic [N_REQ-1:0] req, input owner_t ptr);
    owner_t pick;
    logic   found;
    int     idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        pick  = owner_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic owner_t f_rr_next(input owner_t g);
    return owner_t'((int'(g) + 1) % N_REQ);
  endfunction

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_free_found = 1'b0;
    w_alloc_id   = '0;
    for (int i = N_ID - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_alloc_id   = id_t'(i);
      end
    end
  end

  assign w_start_g     = f_rr_pick(bus.req_start_valid, r_start_rr);
  assign w_start_valid = !rst && (|bus.req_start_valid) && w_free_found;
  assign w_start_fire  = w_start_valid && bus.ts_start_ready;

  // An illegal end never reaches the timestamper. It is consumed here and flagged.
  assign w_end_g     = f_rr_pick(bus.req_end_valid, r_end_rr);
  assign w_end_id    = bus.req_end_id[w_end_g*ID_W +: ID_W];
  assign w_any_end   = !rst && (|bus.req_end_valid);
  assign w_end_legal = r_busy[w_end_id] && !r_ended[w_end_id] && (r_owner[w_end_id] == w_end_g);
  assign w_end_fire  = w_any_end && (!w_end_legal || bus.ts_end_ready);

  assign w_out_owner = r_owner[bus.ts_out_id];
  assign w_out_busy  = r_busy[bus.ts_out_id];
  assign w_out_fire  = !rst && bus.ts_out_valid && w_out_busy && bus.rsp_ready[w_out_owner];
  assign w_out_drop  = !rst && bus.ts_out_valid && !w_out_busy;

  always_comb begin
    bus.req_start_ready = '0;
    bus.req_end_ready   = '0;
    bus.rsp_valid       = '0;
    bus.req_start_ready[w_start_g] = w_start_fire;
    bus.req_end_ready[w_end_g]     = w_end_fire;
    if (w_out_busy) bus.rsp_valid[w_out_owner] = !rst && bus.ts_out_valid;
  end

  assign bus.ts_start_valid = w_start_valid;
  assign bus.ts_start_id    = w_alloc_id;
  assign bus.req_start_id   = {N_REQ{w_alloc_id}};
  assign bus.ts_end_valid   = w_any_end && w_end_legal;
  assign bus.ts_end_id      = w_end_id;
  assign bus.ts_out_ready   = !rst && (w_out_busy ? bus.rsp_ready[w_out_owner] : 1'b1);
  assign bus.rsp_id         = bus.ts_out_id;
  assign bus.rsp_delta      = bus.ts_out_delta;
  assign bus.busy_cnt       = r_busy_cnt;
  assign bus.err_end        = r_err_end;

  // NOTE: state is updated with non-blocking assignments only, so every branch sees the pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-ID tables are real state, not a RAM, so they are cleared on reset like any flop.
      r_busy     <= '0;
      r_ended    <= '0;
      for (int i = 0; i < N_ID; i++) r_owner[i] <= '0;
      r_start_rr <= '0;
      r_end_rr   <= '0;
      r_busy_cnt <= '0;
      r_err_end  <= 1'b0;
    end else begin
      r_err_end <= (w_any_end && !w_end_legal) || w_out_drop;
      if (w_end_fire) begin
        r_end_rr <= f_rr_next(w_end_g);
        if (w_end_legal) r_ended[w_end_id] <= 1'b1;
      end
      if (w_out_fire) begin
        r_busy[bus.ts_out_id]  <= 1'b0;
        r_ended[bus.ts_out_id] <= 1'b0;
      end
      // The allocated ID was free before this edge, so it cannot collide with the ID being freed.
      if (w_start_fire) begin
        r_busy[w_alloc_id]  <= 1'b1;
        r_ended[w_alloc_id] <= 1'b0;
        r_owner[w_alloc_id] <= w_start_g;
        r_start_rr          <= f_rr_next(w_start_g);
      end
      if (w_start_fire != w_out_fire)
        r_busy_cnt <= w_start_fire ? r_busy_cnt + 1'b1 : r_busy_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_ev_id_arbiter.sv
// Bench for ev_id_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a per-ID model of the allocation, ownership and round-robin rules.
module tb_ev_id_arbiter;
  localparam int N_REQ = 2;
  localparam int ID_W  = 3;
  localparam int TS_W  = 8;
  localparam int N_ID  = 1 << ID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ev_id_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .TS_W(TS_W)) bus ();

  ev_id_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model state, one entry per ID
  bit m_busy  [N_ID];
  bit m_ended [N_ID];
  int m_owner [N_ID];
  int m_srr;
  int m_err;
  bit m_errflag;

  // Values observed in the latest step, for the directed checks
  logic [ID_W-1:0]  o_start_id;
  logic [N_REQ-1:0] o_start_ready;
  logic [N_REQ-1:0] o_end_ready;
  logic [N_REQ-1:0] o_rsp_valid;
  logic             o_ts_end_valid;
  logic             o_ts_start_valid;
  logic             o_out_ready;
  logic             o_err_end;
  logic [ID_W:0]    o_cnt;

  function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_ID; i++) begin
      m_busy[i]  = 1'b0;
      m_ended[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_srr     = 0;
    m_err     = 0;
    m_errflag = 1'b0;
  endtask

  task automatic idle();
    bus.req_start_valid = '0;
    bus.req_end_valid   = '0;
    bus.req_end_id      = '0;
    bus.ts_start_ready  = 1'b0;
    bus.ts_end_ready    = 1'b0;
    bus.ts_out_valid    = 1'b0;
    bus.ts_out_id       = '0;
    bus.ts_out_delta    = '0;
    bus.rsp_ready       = '0;
  endtask

  task automatic set_end(input int r, input int id);
    bus.req_end_valid = '0;
    bus.req_end_valid[r] = 1'b1;
    bus.req_end_id[r*ID_W +: ID_W] = ID_W'(id);
  endtask

  // One clock: compare every output with the model at the falling edge, then advance the model
  task automatic step();
    int cnt, alloc, sg, eg, eid, oid, own;
    bit free_found, e_start_valid, start_hs, legal, any_end, res_hs, drop;
    logic [N_REQ-1:0] e_sr, e_er, e_rsp;
    logic e_out_ready;
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < N_ID; i++) cnt += int'(m_busy[i]);
    free_found = 1'b0;
    alloc = 0;
    for (int i = 0; i < N_ID; i++)
      if (!m_busy[i] && !free_found) begin
        free_found = 1'b1;
        alloc = i;
      end
    sg = pick(bus.req_start_valid, m_srr);
    e_start_valid = !rst && (sg >= 0) && free_found;
    start_hs = e_start_valid && bus.ts_start_ready;
    e_sr = '0;
    if (start_hs) e_sr[sg] = 1'b1;
    eg  = pick(bus.req_end_valid, m_err);
    eid = (eg >= 0) ? int'(bus.req_end_id[eg*ID_W +: ID_W]) : 0;
    any_end = !rst && (eg >= 0);
    legal = any_end && m_busy[eid] && (m_owner[eid] == eg) && !m_ended[eid];
    e_er = '0;
    if (any_end) e_er[eg] = legal ? bus.ts_end_ready : 1'b1;
    oid = int'(bus.ts_out_id);
    own = m_owner[oid];
    e_rsp = '0;
    if (rst) e_out_ready = 1'b0;
    else if (m_busy[oid]) begin
      e_rsp[own]  = bus.ts_out_valid;
      e_out_ready = bus.rsp_ready[own];
    end else e_out_ready = 1'b1;
    res_hs = !rst && bus.ts_out_valid && m_busy[oid] && bus.rsp_ready[own];
    drop   = !rst && bus.ts_out_valid && !m_busy[oid];

    o_start_id       = bus.ts_start_id;
    o_start_ready    = bus.req_start_ready;
    o_end_ready      = bus.req_end_ready;
    o_rsp_valid      = bus.rsp_valid;
    o_ts_end_valid   = bus.ts_end_valid;
    o_ts_start_valid = bus.ts_start_valid;
    o_out_ready      = bus.ts_out_ready;
    o_err_end        = bus.err_end;
    o_cnt            = bus.busy_cnt;

    check("busy_cnt", 32'(bus.busy_cnt), 32'(cnt));
    check("err_end", 32'(bus.err_end), 32'(m_errflag));
    check("ts_start_valid", 32'(bus.ts_start_valid), 32'(e_start_valid));
    check("req_start_ready", 32'(bus.req_start_ready), 32'(e_sr));
    if (e_start_valid) check("ts_start_id", 32'(bus.ts_start_id), 32'(alloc));
    if (start_hs) check("req_start_id", 32'(bus.req_start_id[sg*ID_W +: ID_W]), 32'(alloc));
    check("ts_end_valid", 32'(bus.ts_end_valid), 32'(legal));
    if (legal) check("ts_end_id", 32'(bus.ts_end_id), 32'(eid));
    check("req_end_ready", 32'(bus.req_end_ready), 32'(e_er));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
    check("ts_out_ready", 32'(bus.ts_out_ready), 32'(e_out_ready));
    if (bus.ts_out_valid) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(bus.ts_out_id));
      check("rsp_delta", 32'(bus.rsp_delta), 32'(bus.ts_out_delta));
    end

    @(posedge clk);
    if (rst) model_clear();
    else begin
      m_errflag = (any_end && !legal) || drop;
      if (any_end && e_er[eg]) begin
        m_err = (eg + 1) % N_REQ;
        if (legal) m_ended[eid] = 1'b1;
      end
      if (res_hs) begin
        m_busy[oid]  = 1'b0;
        m_ended[oid] = 1'b0;
      end
      if (start_hs) begin
        m_busy[alloc]  = 1'b1;
        m_ended[alloc] = 1'b0;
        m_owner[alloc] = sg;
        m_srr = (sg + 1) % N_REQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int id, r;
    bit found;
    model_clear();
    idle();
    @(posedge clk);
    #1;
    step();
    check("rst_start_valid", 32'(o_ts_start_valid), 32'd0);
    rst = 1'b0;

    // Both requesters start together: round-robin gives ID 0 to R0, then ID 1 to R1
    bus.req_start_valid = 2'b11;
    bus.ts_start_ready  = 1'b1;
    step();
    check("tp1_r0_ready", 32'(o_start_ready), 32'b01);
    check("tp1_r0_id", 32'(o_start_id), 32'd0);
    step();
    check("tp1_r1_ready", 32'(o_start_ready), 32'b10);
    check("tp1_r1_id", 32'(o_start_id), 32'd1);
    idle();
    step();
    check("tp1_cnt", 32'(o_cnt), 32'd2);

    // Fill the pool from R0, stall on the ninth start, then free ID 3
    do_reset();
    bus.req_start_valid = 2'b01;
    bus.ts_start_ready  = 1'b1;
    for (int i = 0; i < N_ID; i++) begin
      step();
      check("tp2_fill_id", 32'(o_start_id), 32'(i));
    end
    step();
    check("tp2_full_ready", 32'(o_start_ready), 32'd0);
    check("tp2_full_cnt", 32'(o_cnt), 32'd8);
    bus.ts_out_valid = 1'b1;
    bus.ts_out_id    = 3'd3;
    bus.ts_out_delta = 8'h11;
    bus.rsp_ready    = 2'b01;
    step();
    check("tp2_free_rsp", 32'(o_rsp_valid), 32'b01);
    check("tp2_no_same_cycle", 32'(o_start_ready), 32'd0);
    bus.ts_out_valid = 1'b0;
    bus.rsp_ready    = 2'b00;
    step();
    check("tp2_realloc_ready", 32'(o_start_ready), 32'b01);
    check("tp2_realloc_id", 32'(o_start_id), 32'd3);

    // R0 owns 0..2, R1 owns 3..5; ends by the wrong owner or repeated ends are flagged
    do_reset();
    bus.ts_start_ready  = 1'b1;
    bus.req_start_valid = 2'b01;
    repeat (3) step();
    bus.req_start_valid = 2'b10;
    repeat (3) step();
    idle();
    bus.ts_end_ready = 1'b1;
    set_end(1, 2);
    step();
    check("tp3_bad_ready", 32'(o_end_ready), 32'b10);
    check("tp3_bad_fwd", 32'(o_ts_end_valid), 32'd0);
    bus.req_end_valid = '0;
    step();
    check("tp3_err", 32'(o_err_end), 32'd1);
    set_end(1, 5);
    step();
    check("tp3_good_fwd", 32'(o_ts_end_valid), 32'd1);
    set_end(1, 5);
    step();
    check("tp3_dup_fwd", 32'(o_ts_end_valid), 32'd0);
    bus.req_end_valid = '0;
    step();
    check("tp3_dup_err", 32'(o_err_end), 32'd1);

    // Result for ID 5 is held by back-pressure from R1, then consumed
    bus.ts_out_valid = 1'b1;
    bus.ts_out_id    = 3'd5;
    bus.ts_out_delta = 8'h2A;
    bus.rsp_ready    = 2'b00;
    repeat (3) begin
      step();
      check("tp4_hold_valid", 32'(o_rsp_valid), 32'b10);
      check("tp4_hold_ready", 32'(o_out_ready), 32'd0);
    end
    bus.rsp_ready = 2'b10;
    step();
    check("tp4_hs_ready", 32'(o_out_ready), 32'd1);
    idle();
    step();
    check("tp4_cnt", 32'(o_cnt), 32'd5);

    // Start, legal end and result handshake in one cycle
    bus.req_start_valid = 2'b01;
    bus.ts_start_ready  = 1'b1;
    bus.ts_end_ready    = 1'b1;
    set_end(1, 3);
    bus.ts_out_valid = 1'b1;
    bus.ts_out_id    = 3'd4;
    bus.ts_out_delta = 8'h77;
    bus.rsp_ready    = 2'b10;
    step();
    check("tp5_start", 32'(o_start_ready), 32'b01);
    check("tp5_not_reissued", 32'(o_start_id), 32'd5);
    check("tp5_end", 32'(o_ts_end_valid), 32'd1);
    check("tp5_out", 32'(o_out_ready), 32'd1);
    idle();
    step();
    check("tp5_cnt", 32'(o_cnt), 32'd5);
    bus.req_start_valid = 2'b01;
    bus.ts_start_ready  = 1'b1;
    step();
    check("tp5_next_id", 32'(o_start_id), 32'd4);

    // Reset with IDs busy clears everything; the first start afterwards gets ID 0
    rst = 1'b1;
    step();
    check("tp6_rst_ready", 32'(o_start_ready), 32'd0);
    rst = 1'b0;
    step();
    check("tp6_cnt", 32'(o_cnt), 32'd0);
    check("tp6_first_id", 32'(o_start_id), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.req_start_valid = N_REQ'($urandom);
      bus.ts_start_ready  = ($urandom_range(0, 3) != 0);
      bus.ts_end_ready    = ($urandom_range(0, 3) != 0);
      bus.req_end_valid   = N_REQ'($urandom) & N_REQ'($urandom);
      for (r = 0; r < N_REQ; r++) begin
        id = $urandom_range(0, N_ID - 1);
        found = 1'b0;
        if ($urandom_range(0, 3) != 0)
          for (int t = 0; t < N_ID; t++)
            if (!found && m_busy[(id + t) % N_ID] && m_owner[(id + t) % N_ID] == r
                && !m_ended[(id + t) % N_ID]) begin
              id = (id + t) % N_ID;
              found = 1'b1;
            end
        bus.req_end_id[r*ID_W +: ID_W] = ID_W'(id);
      end
      bus.ts_out_valid = ($urandom_range(0, 2) == 0);
      id = $urandom_range(0, N_ID - 1);
      found = 1'b0;
      if ($urandom_range(0, 4) != 0)
        for (int t = 0; t < N_ID; t++)
          if (!found && m_busy[(id + t) % N_ID] && m_ended[(id + t) % N_ID]) begin
            id = (id + t) % N_ID;
            found = 1'b1;
          end
      bus.ts_out_id    = ID_W'(id);
      bus.ts_out_delta = TS_W'($urandom);
      bus.rsp_ready    = N_REQ'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
